tx_ser: RTL
===========

TX_SER -- requirements
Module: tx_ser

Interface
REQ-001 Parameter clk_per_bit, default 100, SHALL set the clock cycles per serial bit; legal range 4..4095.
REQ-002 c_tx  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 wr  input  1  SHALL be a byte write strobe, sampled on each c_tx rising edge.
REQ-005 tx_byte  input  8  SHALL be the byte to send, captured when wr=1 and full=0.
REQ-006 txd  output  1  SHALL be the serial line, registered, idle high.
REQ-007 busy  output  1  SHALL be high whenever the FSM is not in IDLE or the FIFO is non-empty.
REQ-008 full  output  1  SHALL be high when the FIFO holds 4 bytes.
REQ-009 ovf  output  1  SHALL pulse high for one cycle when a write is dropped.
REQ-010 flag  output  1  SHALL pulse high for one cycle when a frame's stop bit completes.

Function
REQ-011 Frame SHALL be 8N1: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit held exactly clk_per_bit cycles.
REQ-012 Block SHALL contain a 4-entry FIFO with 2-bit read/write pointers wrapping 3->0 and a 3-bit count 0..4.
REQ-013 Write with full=1 SHALL be dropped, FIFO unchanged, ovf=1 next cycle; full is judged on its pre-edge value even if a pop occurs the same edge.
REQ-014 Simultaneous accepted write and pop SHALL leave count unchanged and preserve FIFO order.
REQ-015 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-016 IDLE: txd=1, bit counter cleared; if count>0, pop head into shift register, txd<=0, go START.
REQ-017 IDLE with count=0 SHALL stay IDLE; a write arriving in that cycle is popped no earlier than the following edge.
REQ-018 START: after clk_per_bit cycles of txd=0, drive bit 0, bit_index<=0, go DATA.
REQ-019 DATA: every clk_per_bit cycles advance bit_index; after bit 7 has been held its full period, txd<=1, go STOP.
REQ-020 STOP: after clk_per_bit cycles of txd=1, flag=1 for one cycle; if count>0 pop and go START with txd<=0 (no idle gap), else go IDLE.
REQ-021 Latency: write accepted at edge k with FSM IDLE and FIFO empty -> txd low after edge k+2; frame spans exactly 10*clk_per_bit cycles of txd.
REQ-022 Cycle counter SHALL be 12 bits, count 0..clk_per_bit-1, and clear on every bit boundary.
REQ-023 wr and tx_byte SHALL have no effect on a frame in progress other than queuing.

Reset
REQ-024 rst=1 SHALL immediately force txd=1, busy=0, full=0, ovf=0, flag=0, FSM=IDLE, pointers, count and counters 0, regardless of clock.
REQ-025 rst asserted mid-frame SHALL abort the frame and discard all queued bytes; no flag pulse.
REQ-026 After rst deasserts, first write SHALL be accepted on the next rising edge.

Verification
REQ-027 clk_per_bit=16, write 0xA5 -> txd: 16 cycles 0, bits 1,0,1,0,0,1,0,1 x16 each, 16 cycles 1; flag once at 160th cycle after start-bit onset.
REQ-028 Write 0x01,0x02,0x03,0x04 back-to-back -> full=1 after 4th write minus one pop; 5th write 0xFF while full -> ovf pulse, 0xFF never appears; 4 frames contiguous, no idle gap, flags at 160-cycle spacing.
REQ-029 Write 0x55 while FIFO has 3 entries and a pop occurs same edge -> accepted, count stays 3, order preserved.
REQ-030 Assert rst at DATA bit 4 of 0x3C with 2 queued bytes -> txd=1 within same cycle, busy=0, no flag, no further frames.
REQ-031 Write 0x00 then 0xFF -> all-zero then all-one data fields exact; busy drops to 0 the cycle after the last flag.

Source files
------------

// File: rtl/tx_ser.sv
// tx_ser: 8N1 serial transmitter fed by a 4-entry byte FIFO.
// txd passes through one output register; flag and busy are aligned to that delayed line.
module tx_ser #(
    parameter int clk_per_bit = 100
) (
    input  logic       c_tx,
    input  logic       rst,
    input  logic       wr,
    input  logic [7:0] tx_byte,
    output logic       txd,
    output logic       busy,
    output logic       full,
    output logic       ovf,
    output logic       flag
);

    localparam logic [11:0] LastCnt = 12'(clk_per_bit - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      r_state;
    logic [7:0]  r_mem [4];
    logic [1:0]  r_wrPtr;
    logic [1:0]  r_rdPtr;
    logic [2:0]  r_count;
    logic [11:0] r_cycleCnt;
    logic [2:0]  r_bitIdx;
    logic [7:0]  r_shift;
    logic        r_line;
    logic        r_txd;
    logic        r_stopDone;
    logic        r_flag;
    logic        r_ovf;

    logic        w_full;
    logic        w_accept;
    logic        w_bitDone;
    logic        w_pop;
    logic [7:0]  w_head;

    assign w_full    = (r_count == 3'd4);
    assign w_accept  = wr && !w_full;
    assign w_bitDone = (r_cycleCnt == LastCnt);
    assign w_pop     = (r_count != 3'd0) &&
                       ((r_state == IDLE) || ((r_state == STOP) && w_bitDone));
    assign w_head    = r_mem[r_rdPtr];

    always_ff @(posedge c_tx) begin
        if (w_accept) begin
            r_mem[r_wrPtr] <= tx_byte;
        end
    end

    // full is judged before this edge's pop, so a write into a full FIFO is dropped
    always_ff @(posedge c_tx or posedge rst) begin
        if (rst) begin
            r_wrPtr <= 2'd0;
            r_rdPtr <= 2'd0;
            r_count <= 3'd0;
            r_ovf   <= 1'b0;
        end else begin
            r_ovf <= wr && w_full;
            if (w_accept) begin
                r_wrPtr <= r_wrPtr + 2'd1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 2'd1;
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge c_tx or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cycleCnt <= 12'd0;
            r_bitIdx   <= 3'd0;
            r_shift    <= 8'd0;
            r_line     <= 1'b1;
            r_stopDone <= 1'b0;
        end else begin
            r_stopDone <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_line     <= 1'b1;
                    r_cycleCnt <= 12'd0;
                    r_bitIdx   <= 3'd0;
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_line  <= 1'b0;
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_bitDone) begin
                        r_cycleCnt <= 12'd0;
                        r_line     <= r_shift[0];
                        r_bitIdx   <= 3'd0;
                        r_state    <= DATA;
                    end else begin
                        r_cycleCnt <= r_cycleCnt + 12'd1;
                    end
                end
                DATA: begin
                    if (w_bitDone) begin
                        r_cycleCnt <= 12'd0;
                        if (r_bitIdx == 3'd7) begin
                            r_line  <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            r_bitIdx <= r_bitIdx + 3'd1;
                            r_shift  <= {1'b0, r_shift[7:1]};
                            r_line   <= r_shift[1];
                        end
                    end else begin
                        r_cycleCnt <= r_cycleCnt + 12'd1;
                    end
                end
                STOP: begin
                    if (w_bitDone) begin
                        r_cycleCnt <= 12'd0;
                        r_stopDone <= 1'b1;
                        if (w_pop) begin
                            r_shift <= w_head;
                            r_line  <= 1'b0;
                            r_state <= START;
                        end else begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_cycleCnt <= r_cycleCnt + 12'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge c_tx or posedge rst) begin
        if (rst) begin
            r_txd  <= 1'b1;
            r_flag <= 1'b0;
        end else begin
            r_txd  <= r_line;
            r_flag <= r_stopDone;
        end
    end

    // busy also covers the flag window so it falls the cycle after the final flag
    assign busy = (r_state != IDLE) || (r_count != 3'd0) || r_stopDone || r_flag;
    assign txd  = r_txd;
    assign flag = r_flag;
    assign ovf  = r_ovf;
    assign full = w_full;

endmodule
